spike_rate_decoder: RTL
=======================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter NUM_CH, default 3, number of spike input channels.
REQ-002 Parameter CNT_W, default 8, width of each per-channel spike count.
REQ-003 Parameter WIN_W, default 8, width of the window-length input.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port enable, input, 1, counting qualifier; when low, the window timer and counts hold.
REQ-007 Port spike_in, input, NUM_CH, one spike pulse per channel per cycle; the neuron spike_out bus connects here.
REQ-008 Port window_len, input, WIN_W, observation window length in enabled cycles; 0 means 2^WIN_W.
REQ-009 Port count_out, output, NUM_CH*CNT_W, the last completed window's counts; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-010 Port sat_out, output, NUM_CH, per-channel flag: that channel's count saturated in the reported window.
REQ-011 Port out_valid, output, 1, count_out and sat_out hold an unconsumed result.
REQ-012 Port out_ready, input, 1, consumer accept; a transfer occurs on any cycle with out_valid and out_ready both high.
REQ-013 Port overrun, output, 1, sticky flag: an unconsumed result was overwritten.

Function
REQ-014 The FSM SHALL have the states IDLE and COUNT; reset enters IDLE.
REQ-015 IDLE SHALL go to COUNT on the first cycle with enable high; that cycle SHALL load the window timer from window_len and count that cycle's spikes as sample 1.
REQ-016 In COUNT, each cycle with enable high SHALL count one sample and add spike_in[i] to acc[i]; cycles with enable low SHALL change nothing.
REQ-017 Each acc[i] SHALL saturate at 2^CNT_W-1; a spike arriving at the saturated value SHALL set that channel's internal sat bit.
REQ-018 The sample completing window_len samples (256 when window_len=0) SHALL include its own spikes.
REQ-019 On that completing edge, acc and sat SHALL copy to count_out and sat_out, and out_valid SHALL be high on the next cycle (latency 1).
REQ-020 On that same edge, acc and sat SHALL clear and the timer SHALL reload from the current window_len; counting continues with no gap cycle.
REQ-021 window_len SHALL be sampled only at window start; changes mid-window SHALL take effect at the next window.
REQ-022 out_valid SHALL stay high, with count_out and sat_out stable, until a transfer occurs.
REQ-023 If a window completes while out_valid is high and out_ready is low, the new result SHALL overwrite the outputs, out_valid SHALL stay high, and overrun SHALL set.
REQ-024 If a window completes on the same cycle as a transfer, the new result SHALL load, out_valid SHALL stay high, and overrun SHALL NOT set.
REQ-025 If enable goes low, the FSM SHALL stay in COUNT with the partial window held, not abandoned.
REQ-026 A window of length 1 SHALL produce one result per enabled cycle.

Reset
REQ-027 While reset is high, the block SHALL hold: state=IDLE, acc=0, timer=0, count_out=0, sat_out=0, out_valid=0, overrun=0.
REQ-028 Reset asserted mid-window SHALL discard the partial counts and any unconsumed result; overrun SHALL clear only on reset.

Structure
REQ-029 The state enum and the NUM_CH, CNT_W and WIN_W defaults SHALL live in the shared package snn_pkg.
REQ-030 Each channel's saturating counter SHALL be one sub-module, sat_counter, instantiated NUM_CH times; the timer, FSM and output stage SHALL stay in the top.

Verification
REQ-031 The bench SHALL check: window_len=4, out_ready=1, spike_in=3'b101 every cycle -> one cycle after the 4th sample, out_valid=1, counts {ch0=4, ch1=0, ch2=4}, sat_out=0.
REQ-032 The bench SHALL check: window_len=0, ch0 spiking all 256 cycles -> ch0 count=255, sat_out[0]=1.
REQ-033 The bench SHALL check: window_len=3, out_ready=0 for two windows -> second result replaces first, overrun=1, out_valid=1 throughout.
REQ-034 The bench SHALL check: window_len=5, enable low for 3 cycles after sample 2 -> result valid after 5 enabled samples, counts exclude spikes presented while enable was low.
REQ-035 The bench SHALL check: window_len changed from 4 to 2 at sample 2 -> current window closes at 4 samples, next window at 2.
REQ-036 The bench SHALL check: reset asserted at sample 2 of 4 -> all outputs 0 immediately; after release, the first result counts only post-reset spikes.

Source files
------------

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared defaults and FSM state type for the spike-rate decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

  localparam int unsigned NUM_CH_DEF = 3;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned WIN_W_DEF  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Per-channel saturating spike accumulator with sticky sat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count_next,
  output logic             sat_next
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             w_at_max;

  // Next values include this cycle's spike so the window-closing sample is counted.
  always_comb begin
    w_at_max   = (r_count == c_CNT_MAX);
    count_next = (inc && !w_at_max) ? r_count + 1'b1 : r_count;
    sat_next   = r_sat | (inc & w_at_max);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= count_next;
      r_sat   <= sat_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Counts spikes per channel over a programmable window and
//               presents each completed window through a valid/ready stage.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]        window_len,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       sat_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam logic [WIN_W:0] c_TMR_ONE = {{WIN_W{1'b0}}, 1'b1};
  localparam logic [WIN_W:0] c_TMR_MAX = {1'b1, {WIN_W{1'b0}}};

  state_e                  r_state;
  logic [WIN_W:0]          r_timer;
  logic [NUM_CH*CNT_W-1:0] r_count_out;
  logic [NUM_CH-1:0]       r_sat_out;
  logic                    r_out_valid;
  logic                    r_overrun;

  logic [WIN_W:0]          w_win_load;
  logic [WIN_W:0]          w_remaining;
  logic                    w_done;
  logic [NUM_CH-1:0]       w_inc;
  logic [NUM_CH*CNT_W-1:0] w_cnt_next;
  logic [NUM_CH-1:0]       w_sat_next;

  // Timer holds samples still owed in the current window; IDLE behaves as a fresh load.
  always_comb begin
    w_win_load  = (window_len == '0) ? c_TMR_MAX : {1'b0, window_len};
    w_remaining = (r_state == IDLE) ? w_win_load : r_timer;
    w_done      = enable && (w_remaining == c_TMR_ONE);
    w_inc       = spike_in & {NUM_CH{enable}};
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sat_counter #(
        .CNT_W (CNT_W)
      ) u_sat_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (w_inc[i]),
        .clr        (w_done),
        .count_next (w_cnt_next[i*CNT_W +: CNT_W]),
        .sat_next   (w_sat_next[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else if (enable) begin
      r_state <= COUNT;
      r_timer <= w_done ? w_win_load : w_remaining - c_TMR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count_out <= '0;
      r_sat_out   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      r_count_out <= w_cnt_next;
      r_sat_out   <= w_sat_next;
      r_out_valid <= 1'b1;
      if (r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign count_out = r_count_out;
  assign sat_out   = r_sat_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire
